// File: rtl/ex_muldiv.sv
// ex_muldiv: EX-stage multiply/divide unit with single-cycle MULT/MULTU and a 32-step restoring divider.
// Optional MADD/MADDU/MSUB/MSUBU accumulate support is compiled in with MULDIV_ACC_EN.
`default_nettype none

// +--------------------------------------------------------------------------+
// | Module   : ex_muldiv                                                     |
// | Brief    : HI/LO multiply/divide execution unit with pipeline stall      |
// | Macro    : MULDIV_ACC_EN enables the MADD/MSUB accumulate family         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        annul_i,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] c_EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] c_EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] c_EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] c_EXE_DIVU_OP  = 8'b0001_1011;
`ifdef MULDIV_ACC_EN
  localparam logic [7:0] c_EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] c_EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] c_EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] c_EXE_MSUBU_OP = 8'b1010_1011;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_ON  = 2'd1,
    DIV_END = 2'd2
`ifdef MULDIV_ACC_EN
    ,
    ACC     = 2'd3
`endif
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [64:0] shreg_q;
  logic [64:0] shreg_d;
  logic [31:0] divisor_q;
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        w_is_div;
  logic        w_is_sdiv;
  logic [31:0] w_dvd_abs;
  logic [31:0] w_dvs_abs;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic [31:0] w_quo_res;
  logic [31:0] w_rem_res;

  assign w_is_div  = (aluop_i == c_EXE_DIV_OP) || (aluop_i == c_EXE_DIVU_OP);
  assign w_is_sdiv = (aluop_i == c_EXE_DIV_OP);
  assign w_dvd_abs = (w_is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
  assign w_dvs_abs = (w_is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

  // Sign-extending to 64 bits first makes the low 64 bits of the product exact.
  assign w_prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
  assign w_prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

  // Remainder never exceeds the divisor, so the 33-bit difference's MSB is the borrow.
  assign w_shift = {shreg_q[63:0], 1'b0};
  assign w_diff  = w_shift[64:32] - {1'b0, divisor_q};
  assign shreg_d = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};

  assign w_quo_res = neg_quo_q ? (~shreg_q[31:0] + 32'd1)  : shreg_q[31:0];
  assign w_rem_res = neg_rem_q ? (~shreg_q[63:32] + 32'd1) : shreg_q[63:32];

`ifdef MULDIV_ACC_EN
  logic [63:0] prod_q;
  logic        acc_sub_q;
  logic        w_is_acc;
  logic        w_acc_signed;
  logic        w_acc_sub;
  logic [63:0] w_acc_res;
  logic        w_unused;

  assign w_is_acc     = (aluop_i == c_EXE_MADD_OP) || (aluop_i == c_EXE_MADDU_OP) ||
                        (aluop_i == c_EXE_MSUB_OP) || (aluop_i == c_EXE_MSUBU_OP);
  assign w_acc_signed = (aluop_i == c_EXE_MADD_OP) || (aluop_i == c_EXE_MSUB_OP);
  assign w_acc_sub    = (aluop_i == c_EXE_MSUB_OP) || (aluop_i == c_EXE_MSUBU_OP);
  assign w_acc_res    = acc_sub_q ? ({hi_i, lo_i} - prod_q) : ({hi_i, lo_i} + prod_q);
  assign w_unused     = shreg_q[64];
`else
  logic w_unused;
  assign w_unused = ^{hi_i, lo_i, shreg_q[64]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      shreg_q   <= 65'd0;
      divisor_q <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`ifdef MULDIV_ACC_EN
      prod_q    <= 64'd0;
      acc_sub_q <= 1'b0;
`endif
    end else if (annul_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 5'd0;
          if (w_is_div) begin
            if (reg2_i == 32'd0) begin
              shreg_q   <= 65'd0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= DIV_END;
            end else begin
              shreg_q   <= {33'd0, w_dvd_abs};
              divisor_q <= w_dvs_abs;
              neg_quo_q <= w_is_sdiv && (reg1_i[31] ^ reg2_i[31]);
              neg_rem_q <= w_is_sdiv && reg1_i[31];
              state_q   <= DIV_ON;
            end
          end
`ifdef MULDIV_ACC_EN
          else if (w_is_acc) begin
            prod_q    <= w_acc_signed ? w_prod_s : w_prod_u;
            acc_sub_q <= w_acc_sub;
            state_q   <= ACC;
          end
`endif
        end
        DIV_ON: begin
          shreg_q <= shreg_d;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DIV_END;
          end
        end
        DIV_END: state_q <= IDLE;
`ifdef MULDIV_ACC_EN
        ACC:     state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // MULT results must appear in the issue cycle, so outputs decode state and inputs directly.
  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = 32'd0;
    lo_o       = 32'd0;
    if (!rst && !annul_i) begin
      case (state_q)
        IDLE: begin
          if (aluop_i == c_EXE_MULT_OP) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = w_prod_s;
          end else if (aluop_i == c_EXE_MULTU_OP) begin
            whilo_o      = 1'b1;
            {hi_o, lo_o} = w_prod_u;
          end else if (w_is_div) begin
            stallreq_o = 1'b1;
          end
`ifdef MULDIV_ACC_EN
          else if (w_is_acc) begin
            stallreq_o = 1'b1;
          end
`endif
        end
        DIV_ON: stallreq_o = 1'b1;
        DIV_END: begin
          whilo_o = 1'b1;
          hi_o    = w_rem_res;
          lo_o    = w_quo_res;
        end
`ifdef MULDIV_ACC_EN
        ACC: begin
          whilo_o      = 1'b1;
          {hi_o, lo_o} = w_acc_res;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv; stimulus pushes expected HI/LO, a monitor pops on whilo_o.
`default_nettype none

module tb_ex_muldiv;

  localparam logic [7:0] MULT  = 8'b0001_1000;
  localparam logic [7:0] MULTU = 8'b0001_1001;
  localparam logic [7:0] DIV   = 8'b0001_1010;
  localparam logic [7:0] DIVU  = 8'b0001_1011;
  localparam logic [7:0] MADD  = 8'b1010_0110;
  localparam logic [7:0] MSUB  = 8'b1010_1010;
  localparam logic [7:0] NOP   = 8'b0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = NOP;
  logic [31:0] reg1 = 32'd0;
  logic [31:0] reg2 = 32'd0;
  logic [31:0] hi_in = 32'd0;
  logic [31:0] lo_in = 32'd10;
  logic        annul = 1'b0;
  logic        stallreq;
  logic        whilo;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .hi_i       (hi_in),
    .lo_i       (lo_in),
    .annul_i    (annul),
    .stallreq_o (stallreq),
    .whilo_o    (whilo),
    .hi_o       (hi_out),
    .lo_o       (lo_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every HI/LO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (whilo) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {hi_out, lo_out}, 64'd0);
        if ({hi_out, lo_out} == 64'd0) begin
          passed--;
          $display("FAIL unexpected_write: whilo=1 with no pending result");
        end
      end else begin
        chk({name_q.pop_front(), "_hilo"}, {hi_out, lo_out}, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input string name, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stalls, input bit exp_wr,
                       input logic [31:0] ehi, input logic [31:0] elo);
    int stalls;
    @(posedge clk); #1;
    aluop = op;
    reg1  = a;
    reg2  = b;
    if (exp_wr) begin
      exp_q.push_back({ehi, elo});
      name_q.push_back(name);
    end
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!stallreq) break;
      stalls++;
      if (stalls > 200) break;
    end
    chk({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    if (!exp_wr) chk({name, "_nowrite"}, {63'd0, whilo}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aluop = MULT; reg1 = 32'd5; reg2 = 32'd3;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {30'd0, stallreq, whilo, hi_out, lo_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    aluop = NOP;

    issue("mult_neg",   MULT,  32'hFFFF_FFFB, 32'd3, 0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    issue("multu_max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001);
    issue("nop",        NOP,   32'd9, 32'd9, 0, 1'b0, 32'd0, 32'd0);
    issue("divu_100_7", DIVU,  32'd100, 32'd7, 33, 1'b1, 32'd2, 32'd14);
    issue("div_m7_2",   DIV,   32'hFFFF_FFF9, 32'd2, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue("div_wrap",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b1, 32'd0, 32'h8000_0000);
    issue("div_7_m2",   DIV,   32'd7, 32'hFFFF_FFFE, 33, 1'b1, 32'd1, 32'hFFFF_FFFD);
    issue("divu_max_1", DIVU,  32'hFFFF_FFFF, 32'd1, 33, 1'b1, 32'd0, 32'hFFFF_FFFF);
    issue("div_by_0",   DIV,   32'd5, 32'd0, 1, 1'b1, 32'd0, 32'd0);

    // Annul a DIVU on its 10th DIV_ON cycle: no write may ever appear for it.
    @(posedge clk); #1;
    aluop = DIVU; reg1 = 32'd1000; reg2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", {63'd0, stallreq}, 64'd0);
    chk("annul_whilo", {63'd0, whilo}, 64'd0);
    @(posedge clk); #1;
    annul = 1'b0;
    aluop = NOP;
    issue("multu_after_annul", MULTU, 32'd2, 32'd3, 0, 1'b1, 32'd0, 32'd6);

`ifdef MULDIV_ACC_EN
    issue("madd_3_4",  MADD, 32'd3, 32'd4, 1, 1'b1, 32'd0, 32'd22);
    issue("msub_1_11", MSUB, 32'd1, 32'd11, 1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`else
    issue("madd_off",  MADD, 32'd3, 32'd4, 0, 1'b0, 32'd0, 32'd0);
    issue("msub_off",  MSUB, 32'd1, 32'd11, 0, 1'b0, 32'd0, 32'd0);
`endif

    @(posedge clk); #1;
    aluop = NOP;
    repeat (3) @(negedge clk);
    chk("pending_results", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
